color_scan_ctrl: RTL and testbench

- Sequencer for the TCS3200-style color sensor on the PMOD JC header.
- Drives the S2/S3 filter-select pins (JC[3:2]) through red, green, blue and clear in turn.
- For each filter: waits a settle interval, then counts rising edges of the sensor's frequency output over a fixed gate window.
- Publishes all four counts together with a one-cycle valid strobe. Replaces manual switch-driven filter selection in the top level.

---
 rtl/color_scan_ctrl.sv | 94 +++++++++
 tb/tb_color_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/color_scan_ctrl.sv
// color_scan_ctrl: steps the TCS3200 filters red/green/blue/clear, counts sensor edges per gate window.
// Define COLOR_CLASSIFY_EN to add the registered dominant-colour output.
module color_scan_ctrl #(
  parameter int GATE_CYCLES = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_freq,
  output logic [1:0]       filter_sel,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt
`ifdef COLOR_CLASSIFY_EN
  ,
  output logic [1:0]       dominant
`endif
);
  localparam int TW = $clog2((GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES) + 1);
  localparam logic [TW-1:0] LAST_SETTLE = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LAST_GATE = TW'(GATE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_idx;
  logic [TW-1:0] r_timer;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic [CNT_W-1:0] r_shadow [4];
  logic r_meta, r_sync_q, r_sync_qq;
  logic w_edge, w_last_settle, w_last_gate;
  assign w_edge = r_sync_q & ~r_sync_qq;
  assign w_last_settle = r_timer == LAST_SETTLE;
  assign w_last_gate = r_timer == LAST_GATE;
  assign busy = r_state != IDLE;
  assign valid = r_state == DONE;
  // index 0..3 = red, green, blue, clear -> {S2,S3} = 00, 11, 01, 10
  assign filter_sel = (r_state == IDLE) ? 2'b10 : {r_idx[0], ^r_idx};
  always_comb begin
    w_next = (r_state == IDLE)   ? (start ? SETTLE : IDLE)
           : (r_state == SETTLE) ? (w_last_settle ? GATE : SETTLE)
           : (r_state == GATE)   ? (!w_last_gate ? GATE : (r_idx == 2'd3) ? DONE : SETTLE)
           : (continuous ? SETTLE : IDLE);
    w_cnt_inc = (w_edge && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
  end
`ifdef COLOR_CLASSIFY_EN
  logic [1:0] w_dom;
  always_comb begin
    w_dom = (r_shadow[0] == '0 && r_shadow[1] == '0 && r_shadow[2] == '0) ? 2'b11
          : (r_shadow[0] >= r_shadow[1] && r_shadow[0] >= r_shadow[2]) ? 2'b00
          : (r_shadow[1] >= r_shadow[2]) ? 2'b01 : 2'b10;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_timer <= '0;
      r_cnt <= '0;
      {r_sync_qq, r_sync_q, r_meta} <= '0;
      r_shadow <= '{default: '0};
      red_cnt <= '0;
      green_cnt <= '0;
      blue_cnt <= '0;
      clear_cnt <= '0;
`ifdef COLOR_CLASSIFY_EN
      dominant <= 2'b11;
`endif
    end else begin
      {r_sync_qq, r_sync_q, r_meta} <= {r_sync_q, r_meta, sensor_freq};
      r_state <= w_next;
      r_timer <= (w_next != r_state) ? '0 : r_timer + 1'b1;
      r_cnt <= (r_state == GATE && !w_last_gate) ? w_cnt_inc : '0;
      if (r_state == GATE && w_last_gate) begin
        r_shadow[r_idx] <= w_cnt_inc;
        if (r_idx != 2'd3) r_idx <= r_idx + 1'b1;
      end
      if (w_next == SETTLE && (r_state == IDLE || r_state == DONE)) r_idx <= '0;
      if (r_state == DONE) begin
        red_cnt <= r_shadow[0];
        green_cnt <= r_shadow[1];
        blue_cnt <= r_shadow[2];
        clear_cnt <= r_shadow[3];
`ifdef COLOR_CLASSIFY_EN
        dominant <= w_dom;
`endif
      end
    end
  end
endmodule

// File: tb/tb_color_scan_ctrl.sv
// tb_color_scan_ctrl: timeline model of scans computed from recorded sensor samples,
// checked every cycle against an 8-bit and a 5-bit (saturating) instance.
module tb_color_scan_ctrl;
  localparam int S = 4, G = 100, W = 8, WS = 5, SCAN = 4 * (S + G);
  logic clk = 0, rst = 1, start = 0, continuous = 0, sensor_freq = 0;
  logic [1:0] fs_a, fs_b;
  logic busy_a, busy_b, valid_a, valid_b;
  logic [W-1:0] r_a, g_a, b_a, c_a;
  logic [WS-1:0] r_b, g_b, b_b, c_b;
`ifdef COLOR_CLASSIFY_EN
  logic [1:0] dom_a, dom_b;
`endif
  always #5 clk = ~clk;
  color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W)) u_a (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .sensor_freq(sensor_freq),
    .filter_sel(fs_a), .busy(busy_a), .valid(valid_a),
    .red_cnt(r_a), .green_cnt(g_a), .blue_cnt(b_a), .clear_cnt(c_a)
`ifdef COLOR_CLASSIFY_EN
    , .dominant(dom_a)
`endif
  );
  color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(WS)) u_b (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .sensor_freq(sensor_freq),
    .filter_sel(fs_b), .busy(busy_b), .valid(valid_b),
    .red_cnt(r_b), .green_cnt(g_b), .blue_cnt(b_b), .clear_cnt(c_b)
`ifdef COLOR_CLASSIFY_EN
    , .dominant(dom_b)
`endif
  );
  int checks = 0, errors = 0;
  int cyc = 0, k = 0, e_fidx = 3;
  bit act = 0, armed = 0, e_busy = 0, e_valid = 0;
  int e_cnt [4] = '{default: 0};
  bit hist [65536];
  int fmap [4] = '{0, 3, 1, 2};
  int mode = 0, per [4] = '{default: 2}, npl [4] = '{default: 0}, ofs = 0, last_f = -1;
  bit cval = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", nm, a, e, cyc);
    end
  endtask
  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction
  function automatic int dom_of(input int r, input int g, input int b);
    if (r == 0 && g == 0 && b == 0) return 3;
    if (r >= g && r >= b) return 0;
    return (g >= b) ? 1 : 2;
  endfunction
  // Scan starting at edge k: filter f gates edges k+f*(S+G)+S .. +G-1; DONE follows edge k+SCAN.
  always @(posedge clk) begin
    cyc++;
    hist[cyc] = sensor_freq;
    if (rst) begin
      act = 0;
      e_cnt = '{default: 0};
      armed = 1;
    end else if (!act) begin
      if (start) begin act = 1; k = cyc; end
    end else if (cyc - k == SCAN + 1) begin
      for (int f = 0; f < 4; f++) begin
        e_cnt[f] = 0;
        for (int n = k + f * (S + G) + S; n < k + f * (S + G) + S + G; n++)
          e_cnt[f] += int'(hist[n-1] && !hist[n-2]);
      end
      if (continuous) k = cyc; else act = 0;
    end
    e_busy = act;
    e_valid = act && (cyc - k == SCAN);
    e_fidx = (!act || cyc - k == SCAN) ? 3 : (cyc - k) / (S + G);
  end
  always @(negedge clk) if (armed) begin
    chk("busy_a", busy_a, e_busy);
    chk("valid_a", valid_a, e_valid);
    chk("fsel_a", fs_a, fmap[e_fidx]);
    chk("busy_b", busy_b, e_busy);
    chk("valid_b", valid_b, e_valid);
    chk("fsel_b", fs_b, fmap[e_fidx]);
    chk("red_a", r_a, sat(e_cnt[0], W));
    chk("green_a", g_a, sat(e_cnt[1], W));
    chk("blue_a", b_a, sat(e_cnt[2], W));
    chk("clear_a", c_a, sat(e_cnt[3], W));
    chk("red_b", r_b, sat(e_cnt[0], WS));
    chk("green_b", g_b, sat(e_cnt[1], WS));
    chk("blue_b", b_b, sat(e_cnt[2], WS));
    chk("clear_b", c_b, sat(e_cnt[3], WS));
`ifdef COLOR_CLASSIFY_EN
    chk("dom_a", dom_a, dom_of(sat(e_cnt[0], W), sat(e_cnt[1], W), sat(e_cnt[2], W)));
    chk("dom_b", dom_b, dom_of(sat(e_cnt[0], WS), sat(e_cnt[1], WS), sat(e_cnt[2], WS)));
`endif
  end
  // Sensor waveform restarts its phase whenever the expected filter changes.
  always @(negedge clk) begin
    if (e_fidx != last_f) begin ofs = 0; last_f = e_fidx; end else ofs++;
    case (mode)
      0: sensor_freq = cval;
      1: sensor_freq = (ofs % per[e_fidx]) < per[e_fidx] / 2;
      2: sensor_freq = ofs >= 6 && ofs < 6 + 4 * npl[e_fidx] && ((ofs - 6) % 4) < 2;
      default: if ($urandom_range(0, 2) == 0) sensor_freq = ~sensor_freq;
    endcase
  end
  task automatic wait_valid(input int lim, input bit fs_chk, output int n);
    n = 0;
    do begin
      @(negedge clk);
      start = 0;
      n++;
      if (fs_chk && n == 1) chk("seq_red", fs_a, 0);
      if (fs_chk && n == 1 + (S + G)) chk("seq_green", fs_a, 3);
      if (fs_chk && n == 1 + 2 * (S + G)) chk("seq_blue", fs_a, 1);
      if (fs_chk && n == 1 + 3 * (S + G)) chk("seq_clear", fs_a, 2);
    end while (!valid_a && n < lim);
    if (!valid_a) chk("valid_timeout", 0, 1);
  endtask
  initial begin
    int n, cntv;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_busy", busy_a, 0);
    chk("idle_fsel", fs_a, 2);
    chk("idle_valid", valid_a, 0);
    chk("idle_red", r_a, 0);
    chk("idle_clear", c_a, 0);
    mode = 1;
    per = '{10, 5, 20, 4};
    start = 1;
    wait_valid(600, 1, n);
    chk("valid_latency", n, SCAN + 1);
    @(negedge clk);
    chk("lit_red", r_a, 10);
    chk("lit_green", g_a, 20);
    chk("lit_blue", b_a, 5);
    chk("lit_clear", c_a, 25);
    chk("end_busy", busy_a, 0);
    chk("end_fsel", fs_a, 2);
    repeat (5) @(negedge clk);
    per = '{2, 2, 2, 2};
    start = 1;
    wait_valid(600, 0, n);
    @(negedge clk);
    chk("sat_red_b", r_b, 31);
    chk("sat_green_b", g_b, 31);
    chk("sat_blue_b", b_b, 31);
    chk("sat_clear_b", c_b, 31);
    chk("nosat_red_a", r_a, 50);
    chk("nosat_clear_a", c_a, 50);
    repeat (5) @(negedge clk);
    mode = 0;
    cval = 1;
    continuous = 1;
    start = 1;
    wait_valid(600, 0, n);
    wait_valid(600, 0, n);
    chk("cont_period", n, SCAN + 1);
    chk("stuck_high_red", r_a, 0);
    repeat (100) @(negedge clk);
    continuous = 0;
    cval = 0;
    wait_valid(600, 0, n);
    @(negedge clk);
    chk("drop_cont_busy", busy_a, 0);
`ifdef COLOR_CLASSIFY_EN
    chk("dom_zero", dom_a, 3);
`endif
    cntv = 0;
    repeat (500) begin @(negedge clk); cntv += int'(valid_a); end
    chk("no_extra_valid", cntv, 0);
    mode = 1;
    per = '{10, 5, 20, 4};
    start = 1;
    repeat (1 + (S + G) + S + 50) begin @(negedge clk); start = 0; end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_fsel", fs_a, 2);
    chk("rst_red", r_a, 0);
    @(negedge clk);
    start = 1;
    wait_valid(600, 0, n);
    chk("rst_relatency", n, SCAN + 1);
    @(negedge clk);
    chk("rst_red2", r_a, 10);
    chk("rst_green2", g_a, 20);
    mode = 3;
    for (int i = 0; i < 2600; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 63) == 0) continuous = ~continuous;
      rst = (i == 1500);
    end
    start = 0;
    continuous = 0;
    rst = 0;
    n = 0;
    while (busy_a && n < 900) begin @(negedge clk); n++; end
    chk("rand_settle_idle", busy_a, 0);
    mode = 2;
    npl = '{12, 3, 12, 5};
    start = 1;
    wait_valid(600, 0, n);
    @(negedge clk);
    chk("pulse_red", r_a, 12);
    chk("pulse_green", g_a, 3);
    chk("pulse_blue", b_a, 12);
    chk("pulse_clear", c_a, 5);
`ifdef COLOR_CLASSIFY_EN
    chk("dom_tie", dom_a, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
